aes_key_sched_ctrl: RTL and testbench
=====================================

# aes_key_sched_ctrl

Sequencer for the AES-128 key expansion. It accepts a cipher key and steps the round counter through 0..9, driving the shared round-constant table and a shared 4-byte S-box. It streams the 11 round keys (round 0..10) over a valid/ready interface to the round datapath. It sits between the key-load path and the cipher round engine.

## Interface
- No parameters; AES-128 only (11 round keys, 10 expansion steps).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE; no done pulse.
- key_in  in  128  cipher key, sampled on the accepted start; w0 = key_in[127:96].
- rcon_round  out  4  round number to the rcon table; equals the current round index rk_idx.
- rcon_in  in  8  combinational rcon for rcon_round (0→01 … 9→36).
- sbox_in  out  32  four bytes to the shared S-box.
- sbox_out  in  32  combinational, byte-wise S-box of sbox_in.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts the key.
- rk_idx  out  4  index of the presented key, 0..10.
- round_key  out  128  current round key {w0,w1,w2,w3}.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse after key 10 handshakes.
- rd_idx  in  4  stored-key read index (see Configuration).
- rd_key  out  128  stored-key read data (see Configuration).

## Operation
- States:
  - IDLE: waiting for start.
  - EMIT: presenting a round key.
  - EXPAND: computing the next round key.
  - FIN: signalling completion.
- IDLE, start=1:
  - Latch key_in into the round-key register.
  - Set rk_idx=0.
  - Next state EMIT.
- EMIT:
  - rk_valid=1.
  - round_key and rk_idx are held stable until the handshake (rk_valid && rk_ready).
  - On handshake with rk_idx=10, go to FIN.
  - On handshake with rk_idx<10, go to EXPAND.
  - Without handshake, stay in EMIT.
- EXPAND, exactly one cycle:
  - sbox_in = RotWord(w3) = {w3[23:0], w3[31:24]}.
  - t = sbox_out ^ {rcon_in, 24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Register w0'..w3'; rk_idx increments; next state EMIT.
- FIN: done=1 for one cycle, then IDLE.
- sbox_in = RotWord(w3) in every state; consumers ignore it outside EXPAND.
- start outside IDLE is ignored; start in the FIN cycle is ignored.
- abort has priority over every transition:
  - Next state IDLE; rk_valid and busy fall the next cycle; no done.
  - rk_idx and round_key are retained (don't-care).
- All datapath arithmetic is XOR.
- rk_idx never exceeds 10.

## Timing
- Reset values: rk_valid=0, busy=0, done=0, rk_idx=0, round_key=0, rd_key=0, rcon_round=0, sbox_in=0; state IDLE.
- Reset asserted mid-expansion returns to IDLE immediately; the stream is lost.
- start in cycle 0 gives rk_valid=1 with key 0 in cycle 1.
- Each subsequent key costs one EXPAND cycle plus the EMIT wait.
- With rk_ready held high:
  - key k is presented in cycle 2k+1.
  - key 10 is presented in cycle 21.
  - done=1 and busy=0 in cycle 22.
- Stalls extend EMIT only; the key is unchanged while rk_ready=0.

## Configuration
- AES_KEY_STORE_EN defined:
  - An 11×128 register array captures round_key at each EMIT handshake.
  - rd_key is registered: rd_key(t+1) = store[rd_idx(t)] for rd_idx 0..10, else 0.
  - The array is reset to 0 and not cleared by abort.
  - Entries from a completed run persist until overwritten.
- AES_KEY_STORE_EN undefined: no array; rd_key is constant 0; rd_idx is ignored.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - key 0 = input key in cycle 1.
  - key 1 = a0fafe1788542cb123a339392a6c7605 in cycle 3.
  - key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 in cycle 21.
  - done in cycle 22.
- Same key with rk_ready low for 5 cycles at key 3: round_key and rk_idx=3 are stable during the stall; all keys still match FIPS-197; done is delayed by 5 cycles.
- start pulsed in cycle 7 of a run, then at done: the cycle-7 start is ignored; the second start begins a new run with key 0 = latched key_in.
- abort during EXPAND at rk_idx=4: rk_valid=0 and busy=0 next cycle; no done; a following start yields the correct key 0.
- rst_n low during EMIT of key 6: outputs are at reset values immediately; the next start runs a full sequence.
- AES_KEY_STORE_EN defined, after the FIPS-197 run: rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later; rd_idx=12 gives 0. Undefined: rd_key=0 always.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
//
// Sequencer for the AES-128 key expansion. It latches a cipher key on an
// accepted start. It then streams the 11 round keys (rk_idx 0..10) over a
// valid/ready handshake. Between consecutive keys it spends one EXPAND cycle
// using the shared rcon table and the shared 4-byte S-box.
//
// Optional feature, selected by the macro AES_KEY_STORE_EN:
//   defined   - an 11x128 store captures every handshaked key; rd_key is
//               a registered read of store[rd_idx] (0 for rd_idx > 10).
//   undefined - no store; rd_key is constant 0 and rd_idx is ignored.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      start request, accepted only in IDLE
//   i_abort      synchronous cancel back to IDLE (no done pulse)
//   i_key_in     cipher key, w0 = key_in[127:96]
//   o_rcon_round round index presented to the rcon table (= rk_idx)
//   i_rcon_in    rcon byte for o_rcon_round
//   o_sbox_in    RotWord(w3) presented to the shared S-box
//   i_sbox_out   byte-wise S-box of o_sbox_in
//   o_rk_valid   round key valid
//   i_rk_ready   consumer accepts the round key
//   o_rk_idx     index of the presented key, 0..10
//   o_round_key  current round key {w0,w1,w2,w3}
//   o_busy       run in progress
//   o_done       one-cycle pulse after key 10 handshakes
//   i_rd_idx     stored-key read index
//   o_rd_key     stored-key read data
module aes_key_sched_ctrl (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [127:0] i_key_in,
    output logic [3:0]   o_rcon_round,
    input  logic [7:0]   i_rcon_in,
    output logic [31:0]  o_sbox_in,
    input  logic [31:0]  i_sbox_out,
    output logic         o_rk_valid,
    input  logic         i_rk_ready,
    output logic [3:0]   o_rk_idx,
    output logic [127:0] o_round_key,
    output logic         o_busy,
    output logic         o_done,
    input  logic [3:0]   i_rd_idx,
    output logic [127:0] o_rd_key
);

    localparam logic [3:0] LastIdx = 4'd10;

    typedef enum logic [1:0] {StIdle, StEmit, StExpand, StFin} state_e;

    state_e         r_state;
    logic           r_rk_valid;
    logic           r_busy;
    logic           r_done;
    logic [3:0]     r_rk_idx;
    logic [127:0]   r_round_key;

    logic [31:0]    w_w0, w_w1, w_w2, w_w3;
    logic [31:0]    w_t;
    logic [31:0]    w_n0, w_n1, w_n2, w_n3;
    logic           w_hs;

    assign w_w0 = r_round_key[127:96];
    assign w_w1 = r_round_key[95:64];
    assign w_w2 = r_round_key[63:32];
    assign w_w3 = r_round_key[31:0];

    // RotWord(w3) is driven in every state; the S-box result is only consumed in EXPAND.
    assign o_sbox_in = {w_w3[23:0], w_w3[31:24]};

    assign w_t  = i_sbox_out ^ {i_rcon_in, 24'h00_0000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign w_hs = r_rk_valid && i_rk_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_rk_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rk_idx    <= 4'd0;
            r_round_key <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                // Key register and index are left as-is; they are don't-care in IDLE.
                r_state    <= StIdle;
                r_rk_valid <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (i_start) begin
                            r_round_key <= i_key_in;
                            r_rk_idx    <= 4'd0;
                            r_rk_valid  <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= StEmit;
                        end
                    end
                    StEmit: begin
                        if (i_rk_ready) begin
                            r_rk_valid <= 1'b0;
                            if (r_rk_idx == LastIdx) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= StFin;
                            end else begin
                                r_state <= StExpand;
                            end
                        end
                    end
                    StExpand: begin
                        r_round_key <= {w_n0, w_n1, w_n2, w_n3};
                        r_rk_idx    <= r_rk_idx + 4'd1;
                        r_rk_valid  <= 1'b1;
                        r_state     <= StEmit;
                    end
                    StFin: begin
                        // A start seen here is dropped; the sequencer must pass through IDLE.
                        r_state <= StIdle;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign o_rcon_round = r_rk_idx;
    assign o_rk_valid   = r_rk_valid;
    assign o_rk_idx     = r_rk_idx;
    assign o_round_key  = r_round_key;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

`ifdef AES_KEY_STORE_EN
    logic [127:0] r_store [11];
    logic [127:0] r_rd_key;

    // Entries survive abort and completed runs; only reset clears them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 11; i++) begin
                r_store[i] <= '0;
            end
            r_rd_key <= '0;
        end else begin
            if (w_hs) begin
                r_store[r_rk_idx] <= r_round_key;
            end
            if (i_rd_idx <= LastIdx) begin
                r_rd_key <= r_store[i_rd_idx];
            end else begin
                r_rd_key <= '0;
            end
        end
    end

    assign o_rd_key = r_rd_key;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^{i_rd_idx, w_hs};
    assign o_rd_key    = '0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [127:0] key_in;
    logic [3:0]   rcon_round;
    logic [7:0]   rcon_in;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    logic         busy;
    logic         done;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] sbox_tab [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Shared tables seen by the DUT.
    always_comb begin
        rcon_in = 8'h00;
        if (rcon_round < 4'd10) rcon_in = rcon_tab[rcon_round];
    end
    assign sbox_out = {sbox_tab[sbox_in[31:24]], sbox_tab[sbox_in[23:16]],
                       sbox_tab[sbox_in[15:8]], sbox_tab[sbox_in[7:0]]};

    aes_key_sched_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_key_in     (key_in),
        .o_rcon_round (rcon_round),
        .i_rcon_in    (rcon_in),
        .o_sbox_in    (sbox_in),
        .i_sbox_out   (sbox_out),
        .o_rk_valid   (rk_valid),
        .i_rk_ready   (rk_ready),
        .o_rk_idx     (rk_idx),
        .o_round_key  (round_key),
        .o_busy       (busy),
        .o_done       (done),
        .i_rd_idx     (rd_idx),
        .o_rd_key     (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [127:0] ref_k [11];
    logic [127:0] got_k [11];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
    endfunction

    // Textbook 44-word key expansion into ref_k.
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0)
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon_tab[i / 4 - 1], 24'h0};
            w[i] = w[i - 4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) ref_k[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // mode: 0 ready always high, 1 ready low 5 cycles at key 3, 2 random ready.
    // Called and returns at a negedge; cycle 0 is the start cycle.
    task automatic run(input logic [127:0] key, input int mode, input int start_at,
                       input bit fin_start, input int abort_at, input int stop_at);
        int   k, present_at, done_at, end_at, stall;
        logic exp_valid, rdy;
        logic [31:0] w3;
        expand(key);
        k = 0; present_at = 1; done_at = 1000; end_at = 1000; stall = 0;
        key_in = key; start = 1'b1; abort = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 1; c < 400; c++) begin
            exp_valid = (k <= 10) && (c >= present_at);
            chk("rk_valid", {127'd0, rk_valid}, {127'd0, exp_valid});
            chk("busy", {127'd0, busy}, {127'd0, k <= 10});
            chk("done", {127'd0, done}, {127'd0, c == done_at});
            if (exp_valid) begin
                w3 = ref_k[k][31:0];
                chk("rk_idx", {124'd0, rk_idx}, 128'(k));
                chk("round_key", round_key, ref_k[k]);
                chk("rcon_round", {124'd0, rcon_round}, 128'(k));
                chk("sbox_in", {96'd0, sbox_in}, {96'd0, w3[23:0], w3[31:24]});
                got_k[k] = round_key;
            end
            if (c == stop_at) return;
            if (c == end_at) break;
            rdy = 1'b1;
            if (mode == 1 && k == 3 && exp_valid && stall < 5) begin
                rdy = 1'b0;
                stall++;
            end else if (mode == 2) begin
                rdy = ($urandom_range(3) != 0);
            end
            rk_ready = rdy;
            start    = (c == start_at) || (fin_start && c == done_at);
            abort    = (c == abort_at);
            if (c == abort_at) begin
                k = 11;
                end_at = c + 3;
            end else if (exp_valid && rdy) begin
                if (k == 10) begin
                    k = 11;
                    done_at = c + 1;
                    end_at = c + 2;
                end else begin
                    k++;
                    present_at = c + 2;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        rk_ready = 1'b1;
    endtask

    task automatic chk_reset_vals();
        chk("rst rk_valid", {127'd0, rk_valid}, 128'd0);
        chk("rst busy", {127'd0, busy}, 128'd0);
        chk("rst done", {127'd0, done}, 128'd0);
        chk("rst rk_idx", {124'd0, rk_idx}, 128'd0);
        chk("rst round_key", round_key, 128'd0);
        chk("rst rd_key", rd_key, 128'd0);
        chk("rst rcon_round", {124'd0, rcon_round}, 128'd0);
        chk("rst sbox_in", {96'd0, sbox_in}, 128'd0);
    endtask

    task automatic chk_read(input int idx);
        logic [127:0] exp;
        rd_idx = 4'(idx);
        @(negedge clk);
        exp = '0;
`ifdef AES_KEY_STORE_EN
        if (idx <= 10) exp = ref_k[idx];
`endif
        chk("rd_key", rd_key, exp);
    endtask

    localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; key_in = '0;
        rk_ready = 1'b1; rd_idx = 4'd0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 vector with ready held high.
        run(FipsKey, 0, 0, 1'b0, 0, 0);
        chk("fips key0", got_k[0], FipsKey);
        chk("fips key1", got_k[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips key10", got_k[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Stored-key readback (or constant 0 without the store).
        chk_read(10);
        chk_read(12);
        chk_read(0);
        chk_read(15);
        chk_read(4);

        // Five-cycle stall at key 3.
        run(FipsKey, 1, 0, 1'b0, 0, 0);
        chk("stall key10", got_k[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Stray start mid-run and in the FIN cycle, then a fresh run.
        run({$urandom, $urandom, $urandom, $urandom}, 0, 7, 1'b1, 0, 0);
        run({$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b0, 0, 0);

        // Abort during EXPAND at rk_idx 4, then a full run.
        run(FipsKey, 0, 0, 1'b0, 10, 0);
        run({$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b0, 0, 0);

        // Asynchronous reset while key 6 is presented.
        run(FipsKey, 0, 0, 1'b0, 0, 13);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        rd_idx = 4'd10;
        @(negedge clk);
        chk("store cleared", rd_key, 128'd0);
        run({$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b0, 0, 0);

        // Randomized keys with random back-pressure.
        for (int i = 0; i < 4; i++) begin
            run({$urandom, $urandom, $urandom, $urandom}, 2, 0, 1'b0, 0, 0);
            chk_read(int'($urandom_range(12)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
